// File: rtl/sseg_scan_ctrl.sv
// Scan controller for a 6-digit seven-segment display: double-buffered frame,
// per-slot blanking dead time and 16-level brightness PWM.
module sseg_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [3:0]  brightness,
  output logic [4:0]  digit,
  output logic [2:0]  digit_pos,
  output logic        blank,
  output logic        frame_start
);

  localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
  localparam int unsigned      ON_SPAN  = CLK_DIV - BLANK_CYC;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       POS_LAST = 3'd5;

  // On-time in clk cycles; 32-bit product, truncating shift.
  function automatic logic [31:0] on_len_f(input logic [3:0] b);
    logic [31:0] prod;
    prod = ON_SPAN * ({28'd0, b} + 32'd1);
    return prod >> 4;
  endfunction

  function automatic logic [4:0] digit_sel_f(input logic [29:0] frame, input logic [2:0] pos);
    logic [4:0] d;
    case (pos)
      3'd0:    d = frame[4:0];
      3'd1:    d = frame[9:5];
      3'd2:    d = frame[14:10];
      3'd3:    d = frame[19:15];
      3'd4:    d = frame[24:20];
      3'd5:    d = frame[29:25];
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pos_q, pos_d;
  logic [29:0]      active_q, active_d;
  logic [29:0]      pend_data_q, pend_data_d;
  logic             pend_q, pend_d;
  logic [3:0]       bright_q, bright_d;
  logic [4:0]       digit_q, digit_d;
  logic             fstart_q, fstart_d;

  logic slot_end, frame_end, accept;

  always_comb begin
    slot_end    = (cnt_q == CNT_LAST);
    frame_end   = slot_end && (pos_q == POS_LAST);
    accept      = frame_valid && !pend_q;

    cnt_d       = slot_end ? '0 : cnt_q + CNT_W'(1);
    pos_d       = pos_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    bright_d    = bright_q;
    digit_d     = digit_q;
    fstart_d    = frame_end;

    if (slot_end) begin
      pos_d    = frame_end ? 3'd0 : pos_q + 3'd1;
      bright_d = brightness;
    end

    // A pending frame is only promoted at the frame boundary, so the
    // displayed frame never changes part way through a scan.
    if (frame_end && pend_q) begin
      active_d = pend_data_q;
      pend_d   = 1'b0;
    end

    // accept requires pend_q=0, so it never collides with promotion above.
    if (accept) begin
      pend_data_d = frame_data;
      pend_d      = 1'b1;
    end

    if (slot_end) begin
      digit_d = digit_sel_f(active_d, pos_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pos_q    <= 3'd0;
      active_q <= 30'd0;
      pend_q   <= 1'b0;
      bright_q <= 4'd0;
      digit_q  <= 5'd0;
      fstart_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      bright_q <= bright_d;
      digit_q  <= digit_d;
      fstart_q <= fstart_d;
    end
  end

  // Pending payload is qualified by pend_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
  end

  // Blanking window: dead time first, then on_len lit cycles, rest dark.
  logic [31:0] cnt_ext, on_end;
  always_comb begin
    cnt_ext = 32'(cnt_q);
    on_end  = BLANK_CYC + on_len_f(bright_q);
    blank   = !((cnt_ext >= BLANK_CYC) && (cnt_ext < on_end));
  end

  assign frame_ready = !pend_q;
  assign digit       = digit_q;
  assign digit_pos   = pos_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: randomized stimulus against a
// cycle-count based reference model of the scan, PWM and frame buffering.
module tb_sseg_scan_ctrl;

  localparam int unsigned CLK_DIV   = 40;
  localparam int unsigned BLANK_CYC = 4;
  localparam int unsigned ON_SPAN   = CLK_DIV - BLANK_CYC;
  localparam int unsigned FRAME     = 6 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] frame_data = 30'd0;
  logic        frame_valid = 1'b0;
  logic [3:0]  brightness = 4'd0;
  logic        frame_ready;
  logic [4:0]  digit;
  logic [2:0]  digit_pos;
  logic        blank;
  logic        frame_start;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .brightness (brightness),
    .digit      (digit),
    .digit_pos  (digit_pos),
    .blank      (blank),
    .frame_start(frame_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] act_vec;
  assign act_vec = {digit, digit_pos, blank, frame_ready, frame_start};

  // Reference model: everything derives from the cycle count since reset.
  int unsigned m_cyc;
  logic [3:0]  m_bright;
  logic [29:0] m_active, m_pdata;
  logic        m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc    <= 0;
      m_bright <= 4'd0;
      m_active <= 30'd0;
      m_pend   <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc % CLK_DIV == CLK_DIV - 1) m_bright <= brightness;
      if ((m_cyc % FRAME == FRAME - 1) && m_pend) begin
        m_active <= m_pdata;
        m_pend   <= 1'b0;
      end else if (frame_valid && !m_pend) begin
        m_pdata <= frame_data;
        m_pend  <= 1'b1;
      end
    end
  end

  function automatic logic [10:0] exp_vec();
    int unsigned c, p, len;
    logic [29:0] sh;
    logic        bl, fs;
    c   = m_cyc % CLK_DIV;
    p   = (m_cyc / CLK_DIV) % 6;
    len = (ON_SPAN * (32'(m_bright) + 32'd1)) / 16;
    sh  = m_active >> (5 * p);
    bl  = !((c >= BLANK_CYC) && (c < BLANK_CYC + len));
    fs  = (m_cyc % FRAME == 0) && (m_cyc != 0);
    return {sh[4:0], 3'(p), bl, !m_pend, fs};
  endfunction

  task automatic wait_phase(input int unsigned ph, input logic need_idle);
    int n;
    n = 0;
    while (!((m_cyc % FRAME == ph) && (!need_idle || !m_pend)) && n < 700) begin
      @(negedge clk);
      n++;
    end
    if (!((m_cyc % FRAME == ph) && (!need_idle || !m_pend))) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d, required %0d", m_cyc % FRAME, m_cyc % FRAME, ph);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_valid = 1'b0;
    brightness = 4'd15;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_vec !== {5'd0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h, required %h", act_vec, {5'd0, 3'd0, 1'b1, 1'b1, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL scan cyc=%0d: got %h, required %h", m_cyc, act_vec, exp_vec());
      end
      if (m_cyc == 40 || m_cyc == 240 || m_cyc == 45) begin
        n_checks++;
        if ((m_cyc == 40 && digit_pos !== 3'd1) || (m_cyc == 240 && (frame_start !== 1'b1 || digit_pos !== 3'd0)) ||
            (m_cyc == 45 && blank !== 1'b0)) begin
          n_fail++;
          $display("FAIL scan_point cyc=%0d: pos=%0d fs=%b blank=%b", m_cyc, digit_pos, frame_start, blank);
        end
      end
    end
  endtask

  task automatic test_brightness();
    logic [3:0] bval;
    int         k;
    brightness = 4'd15;
    wait_phase(10, 1'b0);
    brightness = 4'd0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL bright_change cyc=%0d: got %h, required %h", m_cyc, act_vec, exp_vec());
      end
      if (i == 19 || i == 34 || i == 35) begin
        n_checks++;
        if (blank !== (i == 35)) begin
          n_fail++;
          $display("FAIL bright_point i=%0d: blank %b, required %b", i, blank, (i == 35));
        end
      end
    end
    for (int s = 0; s < 10; s++) begin
      bval = (s == 0) ? 4'd7 : (s == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      k = $urandom_range(0, 39);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        n_checks++;
        if (act_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL bright_rand cyc=%0d b=%0d: got %h, required %h", m_cyc, m_bright, act_vec, exp_vec());
        end
        if (i == k) brightness = bval;
      end
    end
  endtask

  task automatic test_frame();
    logic [29:0] f1, f2;
    f1 = {5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
    f2 = {5'h0F, 5'h0A, 5'h1C, 5'h13, 5'h19, 5'h07};
    brightness = 4'd15;
    wait_phase(10, 1'b1);
    frame_data = f1;
    frame_valid = 1'b1;
    for (int rel = 11; rel <= 600; rel++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL frame cyc=%0d: got %h, required %h", m_cyc, act_vec, exp_vec());
      end
      if (rel == 11) begin
        frame_valid = 1'b0;
        n_checks++;
        if (frame_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_ready_low: got %b, required 0", frame_ready);
        end
      end
      if (rel == 240) begin
        n_checks++;
        if (digit !== 5'h01 || frame_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_swap: digit %h ready %b, required 01 1", digit, frame_ready);
        end
        frame_data = f2;
        frame_valid = 1'b1;
      end
      if (rel == 241) frame_valid = 1'b0;
      if (rel == 280) begin
        n_checks++;
        if (digit !== 5'h02) begin
          n_fail++;
          $display("FAIL frame_d1: digit %h, required 02", digit);
        end
      end
      if (rel == 560 || rel == 599) begin
        n_checks++;
        if (digit !== 5'h13 || digit_pos !== 3'd2) begin
          n_fail++;
          $display("FAIL frame_dp: digit %h pos %0d, required 13 2", digit, digit_pos);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] a, b;
    a = 30'($urandom);
    b = 30'($urandom);
    b[4:0] = a[4:0] ^ 5'h11;
    frame_valid = 1'b0;
    wait_phase(100, 1'b1);
    frame_data = a;
    frame_valid = 1'b1;
    for (int rel = 101; rel <= 490; rel++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d: got %h, required %h", m_cyc, act_vec, exp_vec());
      end
      if (rel == 101) frame_data = b;
      if (rel == 239 || rel == 240 || rel == 241) begin
        n_checks++;
        if (frame_ready !== (rel == 240) || (rel == 240 && digit !== a[4:0])) begin
          n_fail++;
          $display("FAIL b2b_hold rel=%0d: ready %b digit %h, required %b %h", rel, frame_ready, digit, (rel == 240), a[4:0]);
        end
      end
      if (rel == 241) frame_valid = 1'b0;
      if (rel == 480) begin
        n_checks++;
        if (digit !== b[4:0]) begin
          n_fail++;
          $display("FAIL b2b_second: digit %h, required %h", digit, b[4:0]);
        end
      end
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_rand cyc=%0d: got %h, required %h", m_cyc, act_vec, exp_vec());
      end
      if (!(frame_valid && frame_ready === 1'b0)) begin
        frame_valid = ($urandom_range(0, 3) == 0);
        frame_data  = 30'($urandom);
      end
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
    end
    frame_valid = 1'b0;
  endtask

  task automatic test_boundary_accept();
    logic [29:0] old, c;
    frame_valid = 1'b0;
    wait_phase(FRAME - 1, 1'b1);
    old = m_active;
    c = 30'($urandom);
    c[4:0] = old[4:0] ^ 5'h1F;
    frame_data = c;
    frame_valid = 1'b1;
    for (int rel = 240; rel <= 482; rel++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL bnd_acc cyc=%0d: got %h, required %h", m_cyc, act_vec, exp_vec());
      end
      if (rel == 240) begin
        frame_valid = 1'b0;
        n_checks++;
        if (digit !== old[4:0] || frame_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bnd_acc_keep: digit %h ready %b, required %h 0", digit, frame_ready, old[4:0]);
        end
      end
      if (rel == 480) begin
        n_checks++;
        if (digit !== c[4:0]) begin
          n_fail++;
          $display("FAIL bnd_acc_show: digit %h, required %h", digit, c[4:0]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    frame_valid = 1'b0;
    wait_phase(139, 1'b1);
    frame_data = {25'($urandom), 5'h09};
    frame_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (frame_ready !== 1'b0 || digit_pos !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_reset_setup: ready %b pos %0d, required 0 3", frame_ready, digit_pos);
    end
    frame_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (act_vec !== {5'd0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got %h, required %h", act_vec, {5'd0, 3'd0, 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL post_reset cyc=%0d: got %h, required %h", m_cyc, act_vec, exp_vec());
      end
      if (i == 250) begin
        n_checks++;
        if (digit !== 5'd0 || frame_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL pend_lost: digit %h ready %b, required 00 1", digit, frame_ready);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_frame();
    test_back_to_back();
    test_boundary_accept();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
